// File: rtl/axi4_pkg.sv
// AXI4 field widths, encodings and the traffic checker state type.
package axi4_pkg;

   localparam int unsigned C_LEN_W   = 8;
   localparam int unsigned C_SIZE_W  = 3;
   localparam int unsigned C_BURST_W = 2;
   localparam int unsigned C_RESP_W  = 2;

   localparam logic [C_RESP_W-1:0]  C_RESP_OKAY  = 2'b00;
   localparam logic [C_BURST_W-1:0] C_BURST_INCR = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_DONE
   } state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Burst/beat counters with registered base address, beat address, pattern
// data and last-beat flag; reused unchanged by the write and read phases.
module axi4_burst_addr_gen #(
   parameter int unsigned G_ADDR_WIDTH = 7,
   parameter int unsigned G_DATA_WIDTH = 32,
   parameter int unsigned G_BURST_LEN  = 4,
   parameter int unsigned G_NUM_BURSTS = 4,
   parameter int unsigned G_START_ADDR = 0,
   parameter logic [31:0] G_SEED       = 32'hA5A50000
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    clear,
   input  logic                    beat_adv,
   input  logic                    burst_adv,
   output logic [G_ADDR_WIDTH-1:0] base_addr,
   output logic [G_ADDR_WIDTH-1:0] beat_addr,
   output logic [G_DATA_WIDTH-1:0] beat_data,
   output logic                    beat_last,
   output logic                    burst_last
);

   localparam int unsigned BYTES   = G_DATA_WIDTH / 8;
   localparam int unsigned SHIFT   = $clog2(BYTES);
   localparam int unsigned BEAT_W  = $clog2(G_BURST_LEN + 1);
   localparam int unsigned BURST_W = $clog2(G_NUM_BURSTS + 1);

   localparam logic [G_ADDR_WIDTH-1:0] START_A = G_ADDR_WIDTH'(G_START_ADDR);
   localparam logic [G_ADDR_WIDTH-1:0] BYTES_A = G_ADDR_WIDTH'(BYTES);
   localparam logic [G_ADDR_WIDTH-1:0] STRIDE  = G_ADDR_WIDTH'(G_BURST_LEN * BYTES);
   localparam logic [BEAT_W-1:0]       LAST_BEAT  = BEAT_W'(G_BURST_LEN - 1);
   localparam logic [BURST_W-1:0]      LAST_BURST = BURST_W'(G_NUM_BURSTS - 1);

   logic [G_ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
   logic [G_DATA_WIDTH-1:0] data_q, data_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [BURST_W-1:0]      burst_q, burst_d;
   logic                    last_q, last_d;

   function automatic logic [G_DATA_WIDTH-1:0] pattern(input logic [G_ADDR_WIDTH-1:0] a);
      return G_DATA_WIDTH'(G_SEED) ^ G_DATA_WIDTH'(a >> SHIFT);
   endfunction

   // Next counter/address state: clear beats burst advance beats beat advance.
   always_comb begin
      base_d  = base_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      if (clear) begin
         base_d  = START_A;
         addr_d  = START_A;
         beat_d  = '0;
         burst_d = '0;
      end else if (burst_adv) begin
         base_d  = base_q + STRIDE;
         addr_d  = base_q + STRIDE;
         beat_d  = '0;
         burst_d = burst_q + BURST_W'(1);
      end else if (beat_adv) begin
         addr_d  = addr_q + BYTES_A;
         beat_d  = beat_q + BEAT_W'(1);
      end
      data_d = pattern(addr_d);
      last_d = (beat_d == LAST_BEAT);
   end

   // Counter and address registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         base_q  <= START_A;
         addr_q  <= START_A;
         data_q  <= pattern(START_A);
         beat_q  <= '0;
         burst_q <= '0;
         last_q  <= (G_BURST_LEN == 1);
      end else begin
         base_q  <= base_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         last_q  <= last_d;
      end
   end

   assign base_addr  = base_q;
   assign beat_addr  = addr_q;
   assign beat_data  = data_q;
   assign beat_last  = last_q;
   assign burst_last = (burst_q == LAST_BURST);

endmodule

// File: rtl/axi4_burst_traffic_checker.sv
// AXI4 master that writes INCR bursts of a known pattern, reads them back
// and reports a saturating error count plus the first failing address.
module axi4_burst_traffic_checker
   import axi4_pkg::*;
#(
   parameter int unsigned G_ADDR_WIDTH = 7,
   parameter int unsigned G_DATA_WIDTH = 32,
   parameter int unsigned G_ID_WIDTH   = 1,
   parameter int unsigned G_BURST_LEN  = 4,
   parameter int unsigned G_NUM_BURSTS = 4,
   parameter int unsigned G_START_ADDR = 0,
   parameter logic [31:0] G_SEED       = 32'hA5A50000
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [15:0]               err_count,
   output logic [G_ADDR_WIDTH-1:0]   fail_addr,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [G_ADDR_WIDTH-1:0]   m_awaddr,
   output logic [7:0]                m_awlen,
   output logic [2:0]                m_awsize,
   output logic [1:0]                m_awburst,
   output logic [G_ID_WIDTH-1:0]     m_awid,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   output logic [G_DATA_WIDTH-1:0]   m_wdata,
   output logic [G_DATA_WIDTH/8-1:0] m_wstrb,
   output logic                      m_wlast,
   output logic [G_ID_WIDTH-1:0]     m_wid,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   input  logic [1:0]                m_bresp,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   output logic [G_ADDR_WIDTH-1:0]   m_araddr,
   output logic [7:0]                m_arlen,
   output logic [2:0]                m_arsize,
   output logic [1:0]                m_arburst,
   output logic [G_ID_WIDTH-1:0]     m_arid,
   input  logic                      m_rvalid,
   output logic                      m_rready,
   input  logic [G_DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]                m_rresp,
   input  logic                      m_rlast
);

   localparam int unsigned SIZE = $clog2(G_DATA_WIDTH / 8);

   state_t state_q, state_d;
   logic   awvalid_q, awvalid_d, arvalid_q, arvalid_d, wvalid_q, wvalid_d;
   logic   bready_q, bready_d, rready_q, rready_d;
   logic   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic   fail_seen_q, fail_seen_d;
   logic [15:0]             err_q, err_d;
   logic [G_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;

   logic                    gen_clear, beat_adv, burst_adv, err_inc, rd_data_err;
   logic [G_ADDR_WIDTH-1:0] base_addr, beat_addr;
   logic [G_DATA_WIDTH-1:0] beat_data;
   logic                    beat_last, burst_last;

   axi4_burst_addr_gen #(
      .G_ADDR_WIDTH (G_ADDR_WIDTH),
      .G_DATA_WIDTH (G_DATA_WIDTH),
      .G_BURST_LEN  (G_BURST_LEN),
      .G_NUM_BURSTS (G_NUM_BURSTS),
      .G_START_ADDR (G_START_ADDR),
      .G_SEED       (G_SEED)
   ) u_addr_gen (
      .clock      (clock),
      .resetn     (resetn),
      .clear      (gen_clear),
      .beat_adv   (beat_adv),
      .burst_adv  (burst_adv),
      .base_addr  (base_addr),
      .beat_addr  (beat_addr),
      .beat_data  (beat_data),
      .beat_last  (beat_last),
      .burst_last (burst_last)
   );

   // Run sequencing, handshakes and read-back checking.
   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      arvalid_d   = arvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_d       = err_q;
      fail_addr_d = fail_addr_q;
      fail_seen_d = fail_seen_q;
      gen_clear   = 1'b0;
      beat_adv    = 1'b0;
      burst_adv   = 1'b0;
      err_inc     = 1'b0;
      rd_data_err = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               gen_clear   = 1'b1;
               err_d       = '0;
               fail_addr_d = '0;
               fail_seen_d = 1'b0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               busy_d      = 1'b1;
               state_d     = S_WR_ADDR;
            end
         end
         S_WR_ADDR: begin
            if (awvalid_q && m_awready) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b1;
               state_d   = S_WR_DATA;
            end else begin
               awvalid_d = 1'b1;
            end
         end
         S_WR_DATA: begin
            if (wvalid_q && m_wready) begin
               beat_adv = 1'b1;
               if (beat_last) begin
                  wvalid_d = 1'b0;
                  bready_d = 1'b1;
                  state_d  = S_WR_RESP;
               end
            end
         end
         S_WR_RESP: begin
            if (m_bvalid && bready_q) begin
               bready_d = 1'b0;
               err_inc  = (m_bresp != C_RESP_OKAY);
               if (burst_last) begin
                  gen_clear = 1'b1;
                  state_d   = S_RD_ADDR;
               end else begin
                  burst_adv = 1'b1;
                  state_d   = S_WR_ADDR;
               end
            end
         end
         S_RD_ADDR: begin
            if (arvalid_q && m_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end else begin
               arvalid_d = 1'b1;
            end
         end
         S_RD_DATA: begin
            if (m_rvalid && rready_q) begin
               rd_data_err = (m_rdata != beat_data) || (m_rresp != C_RESP_OKAY);
               err_inc     = rd_data_err || (m_rlast != beat_last);
               if (rd_data_err && !fail_seen_q) begin
                  fail_seen_d = 1'b1;
                  fail_addr_d = beat_addr;
               end
               // The beat counter, not rlast, decides when the burst ends.
               if (beat_last) begin
                  rready_d = 1'b0;
                  if (burst_last) begin
                     state_d = S_DONE;
                  end else begin
                     burst_adv = 1'b1;
                     state_d   = S_RD_ADDR;
                  end
               end else begin
                  beat_adv = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (err_inc && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end

      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         busy_d = 1'b0;
         done_d = 1'b1;
         pass_d = (err_d == 16'd0);
      end
   end

   // State and output registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         awvalid_q   <= 1'b0;
         arvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         fail_addr_q <= '0;
         fail_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         arvalid_q   <= arvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         fail_addr_q <= fail_addr_d;
         fail_seen_q <= fail_seen_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_addr = fail_addr_q;

   assign m_awvalid = awvalid_q;
   assign m_awaddr  = base_addr;
   assign m_awlen   = C_LEN_W'(G_BURST_LEN - 1);
   assign m_awsize  = C_SIZE_W'(SIZE);
   assign m_awburst = C_BURST_INCR;
   assign m_awid    = '0;
   assign m_wvalid  = wvalid_q;
   assign m_wdata   = beat_data;
   assign m_wstrb   = '1;
   assign m_wlast   = beat_last;
   assign m_wid     = '0;
   assign m_bready  = bready_q;
   assign m_arvalid = arvalid_q;
   assign m_araddr  = base_addr;
   assign m_arlen   = C_LEN_W'(G_BURST_LEN - 1);
   assign m_arsize  = C_SIZE_W'(SIZE);
   assign m_arburst = C_BURST_INCR;
   assign m_arid    = '0;
   assign m_rready  = rready_q;

endmodule

// File: tb/tb_axi4_burst_traffic_checker.sv
// Scoreboard bench: a small memory slave with fault knobs, expected AW/W/AR
// traffic and run results queued up front, and a negedge monitor popping them.
module tb_axi4_burst_traffic_checker;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic        m_busy, m_done, m_pass;
   logic [15:0] m_err;
   logic [6:0]  m_fail;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [6:0]  m_awaddr, m_araddr;
   logic [7:0]  m_awlen, m_arlen;
   logic [2:0]  m_awsize, m_arsize;
   logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
   logic [0:0]  m_awid, m_arid, m_wid;
   logic [31:0] m_wdata, m_rdata;
   logic [3:0]  m_wstrb;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   axi4_burst_traffic_checker dut (
      .clock(clock), .resetn(resetn), .start(start),
      .busy(m_busy), .done(m_done), .pass(m_pass),
      .err_count(m_err), .fail_addr(m_fail),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wid(m_wid),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast)
   );

   // ---------------- slave model with fault knobs ----------------
   int   flip_word    = -1;
   int   slverr_burst = -1;
   int   ar_delay     = 0;
   logic w_toggle     = 1'b0;
   logic rlast_fault  = 1'b0;

   logic [31:0] mem [32];
   logic        wready_q, bvalid_q, rd_active_q;
   logic [1:0]  bresp_q;
   logic [6:0]  wr_addr_q, rd_base_q;
   int          wr_beat_q, wr_burst_q, rd_beat_q, rd_burst_q, ar_wait_q, rd_word;

   assign m_awready = 1'b1;
   assign m_wready  = w_toggle ? wready_q : 1'b1;
   assign m_bvalid  = bvalid_q;
   assign m_bresp   = bresp_q;
   assign m_arready = (ar_wait_q >= ar_delay);
   assign m_rvalid  = rd_active_q;
   assign m_rresp   = 2'b00;

   always_comb begin
      rd_word = int'(rd_base_q >> 2) + rd_beat_q;
      m_rdata = mem[rd_word[4:0]];
      if (rd_word == flip_word) m_rdata = m_rdata ^ 32'h1;
      m_rlast = (rlast_fault && rd_burst_q == 0) ? (rd_beat_q == 2) : (rd_beat_q == 3);
   end

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= 2'b00; rd_active_q <= 1'b0;
         wr_addr_q <= '0; rd_base_q <= '0; wr_beat_q <= 0; wr_burst_q <= 0;
         rd_beat_q <= 0; rd_burst_q <= 0; ar_wait_q <= 0;
      end else begin
         wready_q <= ~wready_q;
         if (start) begin
            wr_burst_q <= 0;
            rd_burst_q <= 0;
         end
         if (m_awvalid && m_awready) begin
            wr_addr_q <= m_awaddr;
            wr_beat_q <= 0;
         end
         if (m_wvalid && m_wready) begin
            mem[5'(int'(wr_addr_q >> 2) + wr_beat_q)] <= m_wdata;
            wr_beat_q <= wr_beat_q + 1;
            if (m_wlast) begin
               bvalid_q   <= 1'b1;
               bresp_q    <= (wr_burst_q == slverr_burst) ? 2'b10 : 2'b00;
               wr_burst_q <= wr_burst_q + 1;
            end
         end
         if (bvalid_q && m_bready) bvalid_q <= 1'b0;
         if (m_arvalid && !m_arready) ar_wait_q <= ar_wait_q + 1;
         if (m_arvalid && m_arready) begin
            ar_wait_q   <= 0;
            rd_base_q   <= m_araddr;
            rd_beat_q   <= 0;
            rd_active_q <= 1'b1;
         end
         if (m_rvalid && m_rready) begin
            rd_beat_q <= rd_beat_q + 1;
            if (rd_beat_q == 3) begin
               rd_active_q <= 1'b0;
               rd_burst_q  <= rd_burst_q + 1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        pass;
      logic [15:0] err;
      logic [6:0]  fail;
   } res_t;

   logic [6:0]  exp_aw [$];
   logic [6:0]  exp_ar [$];
   logic [32:0] exp_w  [$];
   res_t        exp_res [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: DUT output with empty expectation queue at %0t", name, $time);
   endtask

   task automatic push_traffic();
      for (int k = 0; k < 4; k++) begin
         exp_aw.push_back(7'(16 * k));
         exp_ar.push_back(7'(16 * k));
      end
      for (int i = 0; i < 16; i++) begin
         exp_w.push_back({(i % 4) == 3, 32'hA5A50000 ^ 32'(i)});
      end
   endtask

   task automatic push_res(input logic p, input logic [15:0] e, input logic [6:0] f);
      res_t r;
      r.pass = p; r.err = e; r.fail = f;
      exp_res.push_back(r);
   endtask

   // Monitor: handshakes, stall stability and run results, sampled at negedge.
   logic        aw_stall, w_stall, ar_stall, done_prev;
   logic [6:0]  aw_prev, ar_prev;
   logic [32:0] w_prev;

   always @(negedge clock) begin
      if (!resetn) begin
         aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0; done_prev = 1'b0;
      end else begin
         if (aw_stall) begin
            chk("aw_hold_valid", 32'(m_awvalid), 32'd1);
            chk("aw_hold_addr", 32'(m_awaddr), 32'(aw_prev));
         end
         if (w_stall) begin
            chk("w_hold_valid", 32'(m_wvalid), 32'd1);
            chk("w_hold_data", m_wdata, w_prev[31:0]);
            chk("w_hold_last", 32'(m_wlast), 32'(w_prev[32]));
         end
         if (ar_stall) begin
            chk("ar_hold_valid", 32'(m_arvalid), 32'd1);
            chk("ar_hold_addr", 32'(m_araddr), 32'(ar_prev));
         end
         if (m_awvalid && m_awready) begin
            if (exp_aw.size() == 0) unexpected("aw");
            else begin
               chk("awaddr", 32'(m_awaddr), 32'(exp_aw.pop_front()));
               chk("awlen", 32'(m_awlen), 32'd3);
               chk("awsize_burst", 32'({m_awsize, m_awburst}), 32'({3'd2, 2'b01}));
            end
         end
         if (m_wvalid && m_wready) begin
            if (exp_w.size() == 0) unexpected("w");
            else begin
               logic [32:0] ew;
               ew = exp_w.pop_front();
               chk("wdata", m_wdata, ew[31:0]);
               chk("wlast", 32'(m_wlast), 32'(ew[32]));
               chk("wstrb", 32'(m_wstrb), 32'hF);
            end
         end
         if (m_arvalid && m_arready) begin
            if (exp_ar.size() == 0) unexpected("ar");
            else begin
               chk("araddr", 32'(m_araddr), 32'(exp_ar.pop_front()));
               chk("arlen", 32'(m_arlen), 32'd3);
            end
         end
         if (m_done && !done_prev) begin
            if (exp_res.size() == 0) unexpected("result");
            else begin
               res_t r;
               r = exp_res.pop_front();
               chk("pass", 32'(m_pass), 32'(r.pass));
               chk("err_count", 32'(m_err), 32'(r.err));
               chk("fail_addr", 32'(m_fail), 32'(r.fail));
               chk("busy_at_done", 32'(m_busy), 32'd0);
            end
         end
         aw_stall  = m_awvalid && !m_awready;
         aw_prev   = m_awaddr;
         w_stall   = m_wvalid && !m_wready;
         w_prev    = {m_wlast, m_wdata};
         ar_stall  = m_arvalid && !m_arready;
         ar_prev   = m_araddr;
         done_prev = m_done;
      end
   end

   // ---------------- stimulus ----------------
   task automatic knobs(input int fw, input int sb, input int ad, input logic wt, input logic rf);
      flip_word = fw; slverr_burst = sb; ar_delay = ad; w_toggle = wt; rlast_fault = rf;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run(input string name);
      logic seen;
      seen = 1'b0;
      pulse_start();
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clock);
         seen = m_done;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: done not seen within bound", name);
      end
      @(negedge clock);
      chk({name, "_aw_left"}, 32'(exp_aw.size()), 32'd0);
      chk({name, "_w_left"},  32'(exp_w.size()),  32'd0);
      chk({name, "_ar_left"}, 32'(exp_ar.size()), 32'd0);
      chk({name, "_res_left"}, 32'(exp_res.size()), 32'd0);
   endtask

   initial begin
      logic found;
      resetn = 1'b0;
      start  = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_done", 32'(m_done), 32'd0);
      chk("rst_pass", 32'(m_pass), 32'd0);
      chk("rst_err", 32'(m_err), 32'd0);
      chk("rst_fail_addr", 32'(m_fail), 32'd0);
      chk("rst_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clock);

      knobs(-1, -1, 0, 1'b0, 1'b0); push_traffic(); push_res(1'b1, 16'd0, 7'h00); run("t1_clean");
      knobs(6, -1, 0, 1'b0, 1'b0);  push_traffic(); push_res(1'b0, 16'd1, 7'h18); run("t2_rdata");
      knobs(-1, 2, 0, 1'b0, 1'b0);  push_traffic(); push_res(1'b0, 16'd1, 7'h00); run("t3_bresp");
      knobs(-1, -1, 3, 1'b1, 1'b0); push_traffic(); push_res(1'b1, 16'd0, 7'h00); run("t4_stall");
      knobs(-1, -1, 0, 1'b0, 1'b1); push_traffic(); push_res(1'b0, 16'd2, 7'h00); run("t5_rlast");

      // Reset in the middle of burst 1 write data, then a clean rerun.
      knobs(-1, -1, 0, 1'b0, 1'b0);
      push_traffic();
      pulse_start();
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clock);
         found = m_awvalid && m_awready && (m_awaddr == 7'h10);
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL t6_aw1_timeout: burst 1 AW handshake not seen");
      end
      @(negedge clock);
      chk("t6_wvalid_before_rst", 32'(m_wvalid), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("t6_rst_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
      chk("t6_rst_busy", 32'(m_busy), 32'd0);
      chk("t6_rst_done", 32'(m_done), 32'd0);
      exp_aw.delete();
      exp_w.delete();
      exp_ar.delete();
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      push_traffic();
      push_res(1'b1, 16'd0, 7'h00);
      run("t6_after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
